// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one SRAM request port between shifter/updater rd/wr slots.
// Define SRAM_ARB_STATS_EN to add grant counters and peak outstanding-read tracking.
module sram_req_arbiter #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int TAG_DEPTH_BITS  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] s_rd_addr,
    output logic                       s_rd_ack,
    output logic [SRAM_DATA_WIDTH-1:0] s_rd_data,
    output logic                       s_rd_vld,
    input  logic                       s_wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] s_wr_data,
    output logic                       s_wr_ack,
    input  logic                       u_rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] u_rd_addr,
    output logic                       u_rd_ack,
    output logic [SRAM_DATA_WIDTH-1:0] u_rd_data,
    output logic                       u_rd_vld,
    input  logic                       u_wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] u_wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] u_wr_data,
    output logic                       u_wr_ack,
    output logic                       sram_req,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic                       sram_ack,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    input  logic                       sram_rd_vld,
    output logic                       proto_err
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]                s_grant_cnt,
    output logic [31:0]                u_grant_cnt,
    output logic [TAG_DEPTH_BITS:0]    max_outstanding
`endif
);

    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int DW    = SRAM_DATA_WIDTH;
    localparam int TDB   = TAG_DEPTH_BITS;
    localparam int DEPTH = 1 << TDB;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state, state_nxt;

    // Slot order: 0 S-rd, 1 S-wr, 2 U-rd, 3 U-wr (bit0 = write, bit1 = updater)
    logic [3:0]    req;
    logic [3:0]    pending;
    logic [3:0]    elig;
    logic [3:0]    ack_q;
    logic [AW-1:0] addr_in   [4];
    logic [AW-1:0] slot_addr [4];
    logic [DW-1:0] slot_data [2];
    logic [1:0]    rr;
    logic [1:0]    cur;
    logic [1:0]    pick;
    logic          pick_vld;
    logic          issue;
    logic          done;

    logic [DEPTH-1:0] tag_mem;
    logic [TDB-1:0]   wr_ptr;
    logic [TDB-1:0]   rd_ptr;
    logic [TDB:0]     count;
    logic             full;
    logic             push;
    logic             pop;

    assign req        = {u_wr_req, u_rd_req, s_wr_req, s_rd_req};
    assign addr_in[0] = s_rd_addr;
    assign addr_in[1] = s_wr_addr;
    assign addr_in[2] = u_rd_addr;
    assign addr_in[3] = u_wr_addr;

    assign full = (count == (TDB+1)'(DEPTH));
    assign elig = pending & {1'b1, ~full, 1'b1, ~full};
    assign push = done & ~cur[0];
    assign pop  = sram_rd_vld & (count != '0);

    // Walk downwards so the lowest offset from rr wins
    always_comb begin
        pick     = rr;
        pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[rr + 2'(i)]) begin
                pick     = rr + 2'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   if (sram_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_req = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE:  issue = pick_vld;
            ISSUE: begin
                sram_req = 1'b1;
                done     = sram_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < 4; i++) slot_addr[i] <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !pending[i]) begin
                    pending[i]   <= 1'b1;
                    slot_addr[i] <= addr_in[i];
                end else if (done && cur == 2'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (s_wr_req && !pending[1]) slot_data[0] <= s_wr_data;
            if (u_wr_req && !pending[3]) slot_data[1] <= u_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur          <= '0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
        end else if (issue) begin
            cur          <= pick;
            sram_we      <= pick[0];
            sram_addr    <= slot_addr[pick];
            sram_wr_data <= pick[0] ? slot_data[pick[1]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= '0;
            rr    <= '0;
        end else begin
            ack_q <= done ? (4'b0001 << cur) : 4'b0000;
            if (done) rr <= cur + 2'd1;
        end
    end

    assign s_rd_ack = ack_q[0];
    assign s_wr_ack = ack_q[1];
    assign u_rd_ack = ack_q[2];
    assign u_wr_ack = ack_q[3];

    // Tag FIFO: one bit per outstanding read, 0 = shifter, 1 = updater
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= cur[1];
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_rd_vld  <= 1'b0;
            u_rd_vld  <= 1'b0;
            s_rd_data <= '0;
            u_rd_data <= '0;
            proto_err <= 1'b0;
        end else begin
            s_rd_vld <= pop & ~tag_mem[rd_ptr];
            u_rd_vld <= pop & tag_mem[rd_ptr];
            if (pop && !tag_mem[rd_ptr]) s_rd_data <= sram_rd_data;
            if (pop && tag_mem[rd_ptr])  u_rd_data <= sram_rd_data;
            if (|(req & pending) || (sram_rd_vld && count == '0))
                proto_err <= 1'b1;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_grant_cnt     <= '0;
            u_grant_cnt     <= '0;
            max_outstanding <= '0;
        end else begin
            if (done && !cur[1] && !(&s_grant_cnt)) s_grant_cnt <= s_grant_cnt + 1'b1;
            if (done && cur[1] && !(&u_grant_cnt))  u_grant_cnt <= u_grant_cnt + 1'b1;
            if (count > max_outstanding) max_outstanding <= count;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a queue-based reference model
// compared on every negedge, plus literal checks of grant order and read routing.
module tb_sram_req_arbiter;

    localparam int AW = 19;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          s_rd_req = 1'b0, s_wr_req = 1'b0, u_rd_req = 1'b0, u_wr_req = 1'b0;
    logic [AW-1:0] s_rd_addr = '0, s_wr_addr = '0, u_rd_addr = '0, u_wr_addr = '0;
    logic [DW-1:0] s_wr_data = '0, u_wr_data = '0;
    logic          s_rd_ack, s_wr_ack, u_rd_ack, u_wr_ack;
    logic          s_rd_vld, u_rd_vld;
    logic [DW-1:0] s_rd_data, u_rd_data;
    logic          sram_req, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wr_data;
    logic          sram_ack = 1'b0;
    logic [DW-1:0] sram_rd_data = '0;
    logic          sram_rd_vld = 1'b0;
    logic          proto_err;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0]   s_grant_cnt, u_grant_cnt;
    logic [3:0]    max_outstanding;
`endif

    sram_req_arbiter dut (
        .clk(clk), .reset(reset),
        .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_ack(s_rd_ack),
        .s_rd_data(s_rd_data), .s_rd_vld(s_rd_vld),
        .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .s_wr_ack(s_wr_ack),
        .u_rd_req(u_rd_req), .u_rd_addr(u_rd_addr), .u_rd_ack(u_rd_ack),
        .u_rd_data(u_rd_data), .u_rd_vld(u_rd_vld),
        .u_wr_req(u_wr_req), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
        .u_wr_ack(u_wr_ack),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wr_data(sram_wr_data), .sram_ack(sram_ack),
        .sram_rd_data(sram_rd_data), .sram_rd_vld(sram_rd_vld),
        .proto_err(proto_err)
`ifdef SRAM_ARB_STATS_EN
        , .s_grant_cnt(s_grant_cnt), .u_grant_cnt(u_grant_cnt),
        .max_outstanding(max_outstanding)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // SRAM responder
    int            ack_dly = 0, ret_lat = 2, rel_n = 0, wcnt = 0, cyc = 0;
    bit            auto_ret = 1'b1, inj_vld = 1'b0;
    logic [DW-1:0] inj_data = '0;
    logic [DW-1:0] mem [int];
    logic [DW-1:0] rq_data [$];
    int            rq_due [$];

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return DW'(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sram_ack    = 1'b0;
            sram_rd_vld = 1'b0;
            if (reset) begin
                wcnt = 0;
                rq_data.delete();
                rq_due.delete();
            end else begin
                if (inj_vld) begin
                    sram_rd_vld  = 1'b1;
                    sram_rd_data = inj_data;
                    inj_vld      = 1'b0;
                end else if (rq_due.size() > 0 && rq_due[0] <= cyc && (auto_ret || rel_n > 0)) begin
                    sram_rd_vld  = 1'b1;
                    sram_rd_data = rq_data.pop_front();
                    void'(rq_due.pop_front());
                    if (!auto_ret) rel_n--;
                end
                if (!sram_req) wcnt = 0;
                else if (wcnt >= ack_dly) begin
                    sram_ack = 1'b1;
                    wcnt     = 0;
                    if (sram_we) mem[int'(sram_addr)] = sram_wr_data;
                    else begin
                        rq_data.push_back(rd_val(sram_addr));
                        rq_due.push_back(cyc + ret_lat);
                    end
                end else wcnt++;
            end
        end
    end

    // Reference model: slot table, busy flag, and a queue of outstanding read owners
    logic [3:0]    m_pend;
    logic [AW-1:0] m_addr [4];
    logic [DW-1:0] m_wdat [4];
    int            m_rr, m_cur;
    bit            m_busy;
    int            m_tags [$];
    logic          e_req, e_we, e_svld, e_uvld, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_sdata, e_udata;
    logic [3:0]    e_ack;

    task automatic model_reset();
        m_pend = '0;
        m_rr   = 0;
        m_cur  = 0;
        m_busy = 1'b0;
        m_tags.delete();
        for (int k = 0; k < 4; k++) begin
            m_addr[k] = '0;
            m_wdat[k] = '0;
        end
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_ack = '0;
        e_svld = 0; e_uvld = 0; e_sdata = '0; e_udata = '0; e_err = 0;
    endtask

    task automatic model_step();
        logic [3:0]    rq, pend0;
        logic [AW-1:0] ain [4];
        logic [DW-1:0] din [4];
        bit            done, found;
        int            pk, t, s;
        rq = {u_wr_req, u_rd_req, s_wr_req, s_rd_req};
        ain[0] = s_rd_addr; ain[1] = s_wr_addr; ain[2] = u_rd_addr; ain[3] = u_wr_addr;
        din[0] = '0; din[1] = s_wr_data; din[2] = '0; din[3] = u_wr_data;
        pend0 = m_pend;
        done  = m_busy && sram_ack;
        found = 0;
        pk    = 0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (!found && pend0[s] && (s % 2 == 1 || m_tags.size() < 8)) begin
                    found = 1;
                    pk    = s;
                end
            end
        end
        e_ack  = done ? 4'(1 << m_cur) : 4'b0;
        e_svld = 0;
        e_uvld = 0;
        if (sram_rd_vld) begin
            if (m_tags.size() == 0) e_err = 1;
            else begin
                t = m_tags.pop_front();
                if (t == 0) begin e_svld = 1; e_sdata = sram_rd_data; end
                else begin e_uvld = 1; e_udata = sram_rd_data; end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rq[k]) begin
                if (pend0[k]) e_err = 1;
                else begin
                    m_pend[k] = 1'b1;
                    m_addr[k] = ain[k];
                    m_wdat[k] = din[k];
                end
            end
        end
        if (done) begin
            if (m_cur % 2 == 0) m_tags.push_back(m_cur / 2);
            m_pend[m_cur] = 1'b0;
            m_rr   = (m_cur + 1) % 4;
            m_busy = 0;
            e_req  = 0;
        end else if (found) begin
            m_busy  = 1;
            m_cur   = pk;
            e_req   = 1;
            e_we    = (pk % 2 == 1);
            e_addr  = m_addr[pk];
            e_wdata = (pk % 2 == 1) ? m_wdat[pk] : '0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        chk("sram_bus", 128'({sram_req, sram_we, sram_addr, sram_wr_data}),
            128'({e_req, e_we, e_addr, e_wdata}));
        chk("acks", 128'({u_wr_ack, u_rd_ack, s_wr_ack, s_rd_ack}), 128'(e_ack));
        chk("s_rd_ret", 128'({s_rd_vld, s_rd_data}), 128'({e_svld, e_sdata}));
        chk("u_rd_ret", 128'({u_rd_vld, u_rd_data}), 128'({e_uvld, e_udata}));
        chk("proto_err", 128'(proto_err), 128'(e_err));
    end

    // Event logs for the literal checks
    int            glog [$];
    int            vm [$];
    logic [DW-1:0] vd [$];
    int            ack_hi [4];

    always @(negedge clk) begin
        if (s_rd_ack) begin glog.push_back(0); ack_hi[0]++; end
        if (s_wr_ack) begin glog.push_back(1); ack_hi[1]++; end
        if (u_rd_ack) begin glog.push_back(2); ack_hi[2]++; end
        if (u_wr_ack) begin glog.push_back(3); ack_hi[3]++; end
        if (s_rd_vld) begin vm.push_back(0); vd.push_back(s_rd_data); end
        if (u_rd_vld) begin vm.push_back(1); vd.push_back(u_rd_data); end
    end

    task automatic clear_logs();
        glog.delete();
        vm.delete();
        vd.delete();
        for (int k = 0; k < 4; k++) ack_hi[k] = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic set_req(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (s)
            0: begin s_rd_req = 1; s_rd_addr = a; end
            1: begin s_wr_req = 1; s_wr_addr = a; s_wr_data = d; end
            2: begin u_rd_req = 1; u_rd_addr = a; end
            default: begin u_wr_req = 1; u_wr_addr = a; u_wr_data = d; end
        endcase
    endtask

    task automatic clr_req();
        s_rd_req = 0; s_wr_req = 0; u_rd_req = 0; u_wr_req = 0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (glog.size() < n && c < budget) begin tick(); c++; end
        chk("wait_grants", 128'(glog.size() >= n), 128'(1));
    endtask

    task automatic wait_vld(input int n, input int budget);
        int c = 0;
        while (vm.size() < n && c < budget) begin tick(); c++; end
        chk("wait_vld", 128'(vm.size() >= n), 128'(1));
    endtask

    int         lat;
    logic [15:0] code;

    initial begin
        #1 reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_req", 128'(sram_req), 128'(0));
        chk("rst_err", 128'(proto_err), 128'(0));

        // Single S-rd with delayed ack and return
        clear_logs();
        mem[32'h10] = 72'hAB;
        ack_dly = 3;
        set_req(0, 19'h10, '0);
        tick();
        clr_req();
        lat = 1;
        while (!sram_req && lat < 10) begin tick(); lat++; end
        chk("req_latency", 128'(lat), 128'(2));
        wait_vld(1, 20);
        tick(3);
        chk("s_rd_data", 128'(vd.size() > 0 ? vd[0] : '0), 128'(72'hAB));
        chk("vld_count", 128'(vm.size()), 128'(1));
        chk("vld_master", 128'(vm.size() > 0 ? vm[0] : 9), 128'(0));
        chk("ack_width", 128'(ack_hi[0]), 128'(1));

        // All four slots at once, then U-wr + S-rd
        do_reset();
        clear_logs();
        ack_dly = 0;
        set_req(0, 19'h20, '0);
        set_req(1, 19'h21, 72'h1111);
        set_req(2, 19'h22, '0);
        set_req(3, 19'h23, 72'h2222);
        tick();
        clr_req();
        wait_grants(4, 30);
        code = '0;
        for (int k = 0; k < 4 && k < glog.size(); k++) code = {code[11:0], 4'(glog[k])};
        chk("order4", 128'(code), 128'(16'h0123));
        set_req(3, 19'h24, 72'h3333);
        set_req(0, 19'h25, '0);
        tick();
        clr_req();
        wait_grants(6, 30);
        code = (glog.size() >= 6) ? 16'({4'(glog[4]), 4'(glog[5])}) : 16'hFFFF;
        chk("order_wrap", 128'(code), 128'(16'h03));
        chk("wr_mem", 128'(mem.exists(32'h21) ? mem[32'h21] : '0), 128'(72'h1111));
        tick(15);

        // Tag FIFO fill: 8 alternating S/U reads with no returns
        clear_logs();
        auto_ret = 0;
        rel_n = 0;
        for (int i = 0; i < 8; i++) begin
            set_req((i % 2 == 1) ? 2 : 0, AW'(32'h100 + i), '0);
            tick();
            clr_req();
            wait_grants(i + 1, 20);
        end
        set_req(0, 19'h108, '0);
        set_req(1, 19'h140, 72'h55);
        set_req(3, 19'h141, 72'h66);
        tick();
        clr_req();
        tick(15);
        chk("full_grants", 128'(glog.size()), 128'(10));
        code = (glog.size() >= 10) ? 16'({4'(glog[8]), 4'(glog[9])}) : 16'hFFFF;
        chk("full_wr_order", 128'(code), 128'(16'h31));
        chk("full_blocked", 128'(sram_req), 128'(0));
        rel_n = 1;
        wait_grants(11, 20);
        chk("ninth_read", 128'(glog.size() >= 11 ? glog[10] : 9), 128'(0));
        auto_ret = 1;
        wait_vld(9, 40);
        chk("ret_count", 128'(vm.size()), 128'(9));
        code = (vm.size() >= 3) ? 16'({4'(vm[0]), 4'(vm[1]), 4'(vm[2])}) : 16'hFFFF;
        chk("ret_route", 128'(code), 128'(16'h010));
        chk("ret_data1", 128'(vd.size() >= 2 ? vd[1] : '0), 128'(72'h101));
        chk("ret_data8", 128'(vd.size() >= 9 ? vd[8] : '0), 128'(72'h108));

        // Duplicate S-wr request while pending
        clear_logs();
        chk("err_clean", 128'(proto_err), 128'(0));
        ack_dly = 6;
        set_req(1, 19'h200, 72'hDEAD);
        tick();
        set_req(1, 19'h201, 72'hBEEF);
        tick();
        clr_req();
        tick();
        chk("dup_err", 128'(proto_err), 128'(1));
        wait_grants(1, 30);
        tick(2);
        chk("dup_wdata", 128'(mem.exists(32'h200) ? mem[32'h200] : '0), 128'(72'hDEAD));
        chk("dup_no_wr", 128'(mem.exists(32'h201)), 128'(0));

        // Read data with nothing outstanding
        do_reset();
        clear_logs();
        chk("rst_err2", 128'(proto_err), 128'(0));
        inj_data = 72'h77;
        inj_vld = 1;
        tick(3);
        chk("empty_err", 128'(proto_err), 128'(1));
        chk("empty_no_vld", 128'(vm.size()), 128'(0));

        // Reset during ISSUE with three reads outstanding
        do_reset();
        clear_logs();
        auto_ret = 0;
        ack_dly = 0;
        for (int i = 0; i < 3; i++) begin
            set_req((i == 1) ? 2 : 0, AW'(32'h180 + i), '0);
            tick();
            clr_req();
            wait_grants(i + 1, 20);
        end
        ack_dly = 20;
        set_req(1, 19'h300, 72'h99);
        tick();
        clr_req();
        tick();
        chk("issue_req", 128'(sram_req), 128'(1));
        #2 reset = 1'b1;
        #1 chk("async_req", 128'(sram_req), 128'(0));
        tick(2);
        reset = 1'b0;
        ack_dly = 0;
        auto_ret = 1;
        clear_logs();
        mem[32'h310] = 72'hCAFE;
        set_req(0, 19'h310, '0);
        tick();
        clr_req();
        wait_vld(1, 20);
        tick(2);
        chk("fresh_data", 128'(vd.size() > 0 ? vd[0] : '0), 128'(72'hCAFE));
        chk("fresh_err", 128'(proto_err), 128'(0));
        inj_data = 72'h5;
        inj_vld = 1;
        tick(2);
        inj_vld = 1;
        tick(3);
        chk("late_err", 128'(proto_err), 128'(1));
        chk("late_drop", 128'(vm.size()), 128'(1));

`ifdef SRAM_ARB_STATS_EN
        chk("s_grant_cnt", 128'(s_grant_cnt), 128'(1));
        chk("u_grant_cnt", 128'(u_grant_cnt), 128'(0));
        chk("max_out", 128'(max_outstanding), 128'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares the single SRAM request port between two masters: the shifter (S) and the hash updater (U).
- Each master has a read channel and a write channel. That gives four request slots: S-rd, S-wr, U-rd, U-wr.
- Each slot is latched from a one-cycle request pulse. Slots are served round-robin. Read data returns in order and is routed back by a source-tag FIFO.
- Sits between shifter/updater and the SRAM controller.

Parameters:
- SRAM_ADDR_WIDTH, 19, address width
- SRAM_DATA_WIDTH, 72, data width
- TAG_DEPTH_BITS, 3, log2 of the maximum number of outstanding reads (tag FIFO depth = 8)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_rd_req  in  1  shifter read request pulse
- s_rd_addr  in  SRAM_ADDR_WIDTH  shifter read address
- s_rd_ack  out  1  shifter read accepted
- s_rd_data  out  SRAM_DATA_WIDTH  shifter read data
- s_rd_vld  out  1  shifter read data valid
- s_wr_req  in  1  shifter write request pulse
- s_wr_addr  in  SRAM_ADDR_WIDTH  shifter write address
- s_wr_data  in  SRAM_DATA_WIDTH  shifter write data
- s_wr_ack  out  1  shifter write accepted
- u_rd_req, u_rd_addr, u_rd_ack, u_rd_data, u_rd_vld  (same as the s_rd_* ports)  updater read channel
- u_wr_req, u_wr_addr, u_wr_data, u_wr_ack  (same as the s_wr_* ports)  updater write channel
- sram_req  out  1  request to SRAM, held until sram_ack
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  SRAM_ADDR_WIDTH  address
- sram_wr_data  out  SRAM_DATA_WIDTH  write data
- sram_ack  in  1  SRAM accepted the current request
- sram_rd_data  in  SRAM_DATA_WIDTH  read data, returned in issue order
- sram_rd_vld  in  1  read data valid
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all slot pending bits, the tag FIFO, the round-robin pointer (points to S-rd), proto_err
  - all outputs: sram_req=0, sram_we=0, sram_addr=0, sram_wr_data=0, every *_ack=0, every *_vld=0, every *_data=0
  - Reset in the middle of an operation drops outstanding tags and any held request.
- Slot capture:
  - A req pulse on a slot whose pending bit is 0 latches that slot's addr (and data for writes) and sets pending on the next edge.
  - A req pulse on a slot that is already pending is ignored; the latched contents are unchanged and proto_err is set.
- Arbiter FSM, two states:
  - IDLE: if any slot is pending and eligible, pick the first one at or after the rr pointer in order S-rd, S-wr, U-rd, U-wr. Load sram_addr, sram_wr_data, sram_we and a current-slot register; assert sram_req; go to ISSUE.
  - Read slots are eligible only while the tag FIFO is not full. Write slots are always eligible.
  - ISSUE: hold sram_req and its fields stable until sram_ack. On the sram_ack cycle:
    - deassert sram_req on the next edge
    - pulse the winner's *_ack high for exactly one cycle
    - clear the winner's pending bit
    - set rr pointer = winner + 1 (mod 4)
    - for reads, push the source tag (0 = S, 1 = U)
    - return to IDLE
- Throughput and latency:
  - Minimum of 2 cycles between successive sram_req rising edges.
  - req-pulse-to-sram_req latency with no contention: 2 cycles.
- A slot whose pending bit is cleared on an ack cycle may be re-captured by a req pulse on the following cycle.
- Read return:
  - On sram_rd_vld, pop the tag. Drive the tagged master's *_rd_data and *_rd_vld for one cycle (registered, 1 cycle after sram_rd_vld).
  - The other master's vld stays 0. rd_data holds its last value.
  - sram_rd_vld with an empty tag FIFO: data is dropped and proto_err is set.
  - A push and a pop in the same cycle are both performed; the occupancy count is unchanged.
- Write and read to the same address are not reordered: the order of sram_ack is the service order.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs s_grant_cnt and u_grant_cnt (32 bits each). Each increments on every ack to that master (rd or wr).
  - Both are cleared by reset and saturate at all-ones.
  - Adds output max_outstanding (TAG_DEPTH_BITS+1 bits): the peak tag FIFO occupancy since reset.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Single S-rd: pulse s_rd_req with addr 0x00010, ack after 3 cycles, sram_rd_vld 2 cycles later with data 0xAB -> sram_req rises 2 cycles after the pulse; s_rd_ack is one cycle wide; s_rd_vld=1 with data 0xAB one cycle after sram_rd_vld; u_rd_vld stays 0.
- All four slots pulsed in the same cycle, sram_ack immediate -> grant order S-rd, S-wr, U-rd, U-wr. A second burst in which only U-wr and S-rd are pending -> S-rd first (pointer has wrapped to S-rd).
- Tag FIFO fill: 8 reads acked with no sram_rd_vld -> a 9th read is not issued while pending writes are still issued. One sram_rd_vld -> the 9th read is issued.
- Interleaved returns: read tags S, U, S -> vld pulses go to s, u, s in that order with matching data.
- A second s_wr_req pulse while S-wr is pending -> proto_err=1 and the originally latched addr/data are written. sram_rd_vld with the tag FIFO empty -> proto_err=1 and no *_vld.
- Reset asserted while in ISSUE with 3 tags outstanding -> sram_req=0 immediately (asynchronous). After release, a fresh S-rd proceeds normally; late sram_rd_vld pulses set proto_err and are dropped.
